// File: rtl/bp_update_scheduler.sv
// Shares the single-ported branch-history table between fetch lookups and buffered commit updates.
// Zero-latency combinational arbitration; an aged or full update queue stalls fetch, and upd_full back-pressures the ROB.
module bp_update_scheduler #(
  parameter int DEPTH      = 4,
  parameter int IDX_W      = 6,
  parameter int HASH_PRIME = 337,
  parameter int MAX_WAIT   = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             lookup_req,
  input  logic [31:0]      lookup_pc,
  output logic             lookup_grant,
  output logic             stall_fetch,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  output logic             upd_full,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_idx,
  output logic             tbl_taken
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } upd_ent_t;

  upd_ent_t          fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;

  upd_ent_t head;
  logic     active, force_drain, drain, lookup, push;

  function automatic logic [IDX_W-1:0] pc_hash(input logic [31:0] pc);
    logic [31:0] prod;
    prod = pc * 32'(HASH_PRIME);
    return prod[IDX_W-1:0];
  endfunction

  assign upd_full = (count == CNT_W'(DEPTH));
  assign head     = fifo_mem[rd_ptr];

  always_comb begin
    active       = rdy_in && !rst_in;
    force_drain  = upd_full || (wait_cnt == WAIT_W'(MAX_WAIT));
    drain        = active && (count != '0) && (!lookup_req || force_drain);
    lookup       = active && lookup_req && !drain;
    push         = rdy_in && upd_valid && !upd_full;

    lookup_grant = lookup;
    // While paused fetch is held regardless of whether it is requesting.
    stall_fetch  = !rst_in && (!rdy_in || (drain && lookup_req));
    tbl_en       = drain || lookup;
    tbl_we       = drain;
    tbl_taken    = drain && head.taken;
    tbl_idx      = '0;
    if (drain)
      tbl_idx = pc_hash(head.pc);
    else if (lookup)
      tbl_idx = pc_hash(lookup_pc);

    count_nxt = count + CNT_W'(push) - CNT_W'(drain);

    wait_nxt = wait_cnt;
    if (drain || (count_nxt == '0))
      wait_nxt = '0;
    else if (lookup && (count != '0) && (wait_cnt != WAIT_W'(MAX_WAIT)))
      wait_nxt = wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else if (rdy_in) begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (drain)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Storage has no reset; entries are only visible through count.
  always_ff @(posedge clk_in) begin
    if (push && !rst_in)
      fifo_mem[wr_ptr] <= '{pc: upd_pc, taken: upd_taken};
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler: stimulus queues expected per-cycle outputs, a monitor compares them.
module tb_bp_update_scheduler;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        lookup_req = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        lookup_grant, stall_fetch;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        upd_full, tbl_en, tbl_we, tbl_taken;
  logic [5:0]  tbl_idx;

  bp_update_scheduler #(.DEPTH(4), .IDX_W(6), .HASH_PRIME(337), .MAX_WAIT(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .lookup_req(lookup_req), .lookup_pc(lookup_pc),
    .lookup_grant(lookup_grant), .stall_fetch(stall_fetch),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_full(upd_full), .tbl_en(tbl_en), .tbl_we(tbl_we),
    .tbl_idx(tbl_idx), .tbl_taken(tbl_taken)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic       grant;
    logic       stall;
    logic       en;
    logic       we;
    logic [5:0] idx;
    logic       taken;
    logic       full;
  } out_t;

  typedef struct {
    int   tag;
    out_t o;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic out_t mk(input logic g, input logic s, input logic en, input logic we,
                              input logic [5:0] idx, input logic tk, input logic fu);
    out_t r;
    r.grant = g; r.stall = s; r.en = en; r.we = we;
    r.idx = idx; r.taken = tk; r.full = fu;
    return r;
  endfunction

  task automatic step(input int tag, input logic r, input logic rdy, input logic lr,
                      input logic [31:0] lp, input logic uv, input logic [31:0] up,
                      input logic ut, input out_t e);
    exp_t x;
    @(posedge clk_in);
    #1;
    rst_in = r; rdy_in = rdy; lookup_req = lr; lookup_pc = lp;
    upd_valid = uv; upd_pc = up; upd_taken = ut;
    x.tag = tag;
    x.o   = e;
    exp_q.push_back(x);
  endtask

  always @(negedge clk_in) begin
    exp_t x;
    out_t a;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      a = {lookup_grant, stall_fetch, tbl_en, tbl_we, tbl_idx, tbl_taken, upd_full};
      checks++;
      if (a !== x.o) begin
        errors++;
        $display("FAIL step%0d outputs: got grant=%b stall=%b en=%b we=%b idx=%0d taken=%b full=%b, want grant=%b stall=%b en=%b we=%b idx=%0d taken=%b full=%b",
                 x.tag, a.grant, a.stall, a.en, a.we, a.idx, a.taken, a.full,
                 x.o.grant, x.o.stall, x.o.en, x.o.we, x.o.idx, x.o.taken, x.o.full);
      end
    end
    if (!rst_in && rdy_in && upd_valid && upd_full)
      $display("protocol note: push while full at t=%0t, entry is expected to be dropped", $time);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t z;
    z = mk(0, 0, 0, 0, 6'd0, 0, 0);
    // reset
    step(1,  1, 1, 0, 32'h0, 0, 32'h0, 0, z);
    step(2,  1, 1, 0, 32'h0, 0, 32'h0, 0, z);
    // hash on lookups
    step(3,  0, 1, 1, 32'h10, 0, 32'h0, 0, mk(1, 0, 1, 0, 6'd16, 0, 0));
    step(4,  0, 1, 1, 32'hFFFF_FFFF, 0, 32'h0, 0, mk(1, 0, 1, 0, 6'd47, 0, 0));
    step(5,  0, 1, 0, 32'h0, 0, 32'h0, 0, z);
    // idle drain, no bypass
    step(6,  0, 1, 0, 32'h0, 1, 32'h4, 1, z);
    step(7,  0, 1, 0, 32'h0, 0, 32'h0, 0, mk(0, 0, 1, 1, 6'd4, 1, 0));
    step(8,  0, 1, 0, 32'h0, 0, 32'h0, 0, z);
    // starvation bound
    step(9,  0, 1, 1, 32'h10, 1, 32'h5, 0, mk(1, 0, 1, 0, 6'd16, 0, 0));
    step(10, 0, 1, 1, 32'h7, 0, 32'h0, 0, mk(1, 0, 1, 0, 6'd55, 0, 0));
    step(11, 0, 1, 1, 32'h7, 0, 32'h0, 0, mk(1, 0, 1, 0, 6'd55, 0, 0));
    step(12, 0, 1, 1, 32'h7, 0, 32'h0, 0, mk(1, 0, 1, 0, 6'd55, 0, 0));
    step(13, 0, 1, 1, 32'h7, 0, 32'h0, 0, mk(0, 1, 1, 1, 6'd21, 0, 0));
    step(14, 0, 1, 1, 32'h7, 0, 32'h0, 0, mk(1, 0, 1, 0, 6'd55, 0, 0));
    // full FIFO, dropped 5th push, in-order drain
    step(15, 0, 1, 1, 32'h9, 1, 32'h3,  1, mk(1, 0, 1, 0, 6'd25, 0, 0));
    step(16, 0, 1, 1, 32'h9, 1, 32'hB,  0, mk(1, 0, 1, 0, 6'd25, 0, 0));
    step(17, 0, 1, 1, 32'h9, 1, 32'hD,  1, mk(1, 0, 1, 0, 6'd25, 0, 0));
    step(18, 0, 1, 1, 32'h9, 1, 32'h21, 1, mk(1, 0, 1, 0, 6'd25, 0, 0));
    step(19, 0, 1, 1, 32'h9, 1, 32'h1F, 1, mk(0, 1, 1, 1, 6'd51, 1, 1));
    step(20, 0, 1, 1, 32'h9, 0, 32'h0,  0, mk(1, 0, 1, 0, 6'd25, 0, 0));
    step(21, 0, 1, 0, 32'h0, 0, 32'h0,  0, mk(0, 0, 1, 1, 6'd59, 0, 0));
    step(22, 0, 1, 0, 32'h0, 0, 32'h0,  0, mk(0, 0, 1, 1, 6'd29, 1, 0));
    step(23, 0, 1, 0, 32'h0, 0, 32'h0,  0, mk(0, 0, 1, 1, 6'd49, 1, 0));
    step(24, 0, 1, 0, 32'h0, 0, 32'h0,  0, z);
    // advance pointers to slot 3 so the next entries wrap
    step(25, 0, 1, 0, 32'h0, 1, 32'h1001, 0, z);
    step(26, 0, 1, 0, 32'h0, 0, 32'h0,    0, mk(0, 0, 1, 1, 6'd17, 0, 0));
    // pause, then concurrent push/pop across the wrap
    step(27, 0, 1, 1, 32'h10, 1, 32'h2, 0, mk(1, 0, 1, 0, 6'd16, 0, 0));
    step(28, 0, 1, 1, 32'h10, 1, 32'h6, 1, mk(1, 0, 1, 0, 6'd16, 0, 0));
    step(29, 0, 0, 1, 32'h10, 1, 32'h8000_0003, 1, mk(0, 1, 0, 0, 6'd0, 0, 0));
    step(30, 0, 0, 1, 32'h10, 1, 32'h8000_0003, 1, mk(0, 1, 0, 0, 6'd0, 0, 0));
    step(31, 0, 1, 1, 32'h10, 0, 32'h0, 0, mk(1, 0, 1, 0, 6'd16, 0, 0));
    step(32, 0, 1, 1, 32'h10, 0, 32'h0, 0, mk(1, 0, 1, 0, 6'd16, 0, 0));
    step(33, 0, 1, 1, 32'h10, 1, 32'h8000_0003, 1, mk(0, 1, 1, 1, 6'd34, 0, 0));
    step(34, 0, 1, 0, 32'h0, 0, 32'h0, 0, mk(0, 0, 1, 1, 6'd38, 1, 0));
    step(35, 0, 1, 0, 32'h0, 0, 32'h0, 0, mk(0, 0, 1, 1, 6'd51, 1, 0));
    step(36, 0, 1, 0, 32'h0, 0, 32'h0, 0, z);
    // reset mid-run with three entries pending
    step(37, 0, 1, 1, 32'h9, 1, 32'h3, 1, mk(1, 0, 1, 0, 6'd25, 0, 0));
    step(38, 0, 1, 1, 32'h9, 1, 32'h5, 0, mk(1, 0, 1, 0, 6'd25, 0, 0));
    step(39, 0, 1, 1, 32'h9, 1, 32'h7, 1, mk(1, 0, 1, 0, 6'd25, 0, 0));
    step(40, 1, 1, 0, 32'h0, 0, 32'h0, 0, z);
    step(41, 0, 1, 0, 32'h0, 0, 32'h0, 0, z);
    step(42, 0, 1, 1, 32'h10, 0, 32'h0, 0, mk(1, 0, 1, 0, 6'd16, 0, 0));
    step(43, 0, 1, 0, 32'h0, 0, 32'h0, 0, z);

    @(posedge clk_in);
    @(posedge clk_in);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
- Arbitrates the single-ported branch-history table (2-bit counters, indexed by hashed PC) between two users: the fetch-side lookup and the commit-side counter update.
- Commit updates from the ROB are buffered in a small in-order FIFO and drained into idle table cycles.
- An age counter bounds how long an update can wait; when it must drain, the lookup is stalled and fetch is held.
- Sits between fetch/PC logic, the ROB commit port and the table storage.

Parameters:
- DEPTH, 4, update FIFO entries (power of two, ≥2).
- IDX_W, 6, table index width (table has 2^IDX_W entries).
- HASH_PRIME, 337, multiplier for the index hash.
- MAX_WAIT, 3, cycles the FIFO head may be passed over before the update is forced.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, synchronous active-high reset.
- rdy_in, input, 1, global ready; low pauses the block.
- lookup_req, input, 1, fetch wants a prediction this cycle.
- lookup_pc, input, 32, PC of the fetched branch.
- lookup_grant, output, 1, table read is performed for lookup_pc this cycle.
- stall_fetch, output, 1, lookup denied; fetch must hold its PC and retry.
- upd_valid, input, 1, ROB commits a B-type branch.
- upd_pc, input, 32, committed branch PC.
- upd_taken, input, 1, resolved direction.
- upd_full, output, 1, FIFO full; ROB must not commit a branch this cycle.
- tbl_en, output, 1, table access enable.
- tbl_we, output, 1, 1 = counter update, 0 = read.
- tbl_idx, output, IDX_W, table index.
- tbl_taken, output, 1, update direction; the table saturating-increments on 1 and decrements on 0.

Behaviour:
- **Index hash:** idx = low IDX_W bits of the 32-bit product (pc * HASH_PRIME). It is applied to lookup_pc for reads and to the stored PC at pop time for writes.
- **State:** FIFO of {pc[31:0], taken}, plus wr_ptr, rd_ptr, count (0..DEPTH) and wait_cnt (0..MAX_WAIT, saturating).
- **Reset (rst_in=1 at posedge):**
  - Pointers, count and wait_cnt are cleared to 0; FIFO contents are don't-care.
  - Reset has priority over rdy_in.
  - A mid-operation reset discards all pending updates.
- **Reset-state outputs:** upd_full=0, lookup_grant=0, stall_fetch=0, tbl_en=0, tbl_we=0, tbl_idx=0, tbl_taken=0.
- **Combinational outputs:** all arbitration outputs are driven combinationally in the same cycle as the request; the table sees the access at the next posedge.
- **Arbitration, rdy_in=1:**
  - force = (count==DEPTH) or (wait_cnt==MAX_WAIT).
  - Drain when count>0 and (!lookup_req or force):
    - tbl_en=1, tbl_we=1, tbl_idx=hash(head.pc), tbl_taken=head.taken; pop at posedge.
    - If lookup_req is high in that cycle: lookup_grant=0, stall_fetch=1.
  - Lookup when lookup_req and not draining: tbl_en=1, tbl_we=0, tbl_idx=hash(lookup_pc), lookup_grant=1, stall_fetch=0.
  - Idle otherwise: tbl_en=0; the other outputs are 0.
- **wait_cnt** (updated at posedge):
  - 0 on a pop or when count==0 after the cycle.
  - Otherwise +1 when the head was passed over for a lookup, saturating at MAX_WAIT.
- **Push:** upd_valid && !upd_full writes {upd_pc, upd_taken} at wr_ptr at posedge.
  - upd_full = (count==DEPTH), from the registered count only.
  - A push while full is dropped (protocol violation; the bench flags it).
- **Simultaneous push and pop:** allowed; count is unchanged and pointers wrap mod DEPTH.
  - Push into an empty FIFO is not bypassed; the entry becomes drainable the next cycle.
- **Ordering:** updates drain strictly in commit order; the same PC may appear in multiple entries.
- **No flush input:** committed updates survive ROB roll-back.
- **rdy_in=0:**
  - No push, no pop; all state holds.
  - tbl_en=0, lookup_grant=0, stall_fetch=1.
  - upd_full still reflects count.

Test Plan:
- **Reset mid-run:** reset with count=3 → next cycle count=0, upd_full=0, tbl_en=0; a lookup_req is granted immediately.
- **Hash:** idle FIFO, lookup_req=1, lookup_pc=0x0000_0010 → lookup_grant=1, tbl_we=0, tbl_idx=(16*337)%64=16.
- **Idle drain:** push {pc=0x4, taken=1}, then lookup_req=0 → the next cycle drives tbl_we=1, tbl_idx=(4*337)%64=4, tbl_taken=1; count returns to 0.
- **Starvation bound:** one entry queued, lookup_req held high with MAX_WAIT=3 → lookup granted 3 cycles, 4th cycle drains with stall_fetch=1 and lookup_grant=0, 5th cycle lookup granted again.
- **Full FIFO:** 4 pushes with lookup_req=1 → upd_full=1; a 5th push is dropped; the drain is forced the same cycle; upd_full=0 the cycle after; the entries drain in commit order.
- **Pause and concurrent push/pop:**
  - rdy_in=0 for 2 cycles with count=2 → count and wait_cnt unchanged, stall_fetch=1, tbl_en=0.
  - Then simultaneous push and pop → count stays 2 and pointers wrap correctly across DEPTH.
